time_of_day_clock: RTL and testbench
====================================

Name: time_of_day_clock

Overview:
- Real-time time-of-day counter that sits directly upstream of the dose-time comparator.
- Divides the system clock down to a 1 Hz tick and keeps 24-hour hours/minutes/seconds.
- Drives the comparator's `seconds`, `minutes`, `hours` and `secondP` inputs.
- The user or the front panel loads the time through a strobed set port.

Parameters:
- CLK_HZ, 50000000, system clock frequency; the prescaler terminal count is CLK_HZ-1.
- SIM_DIV, 10, prescaler length used only when SIM_PRESCALE_EN is defined.
- PRESC_W, 26, prescaler counter width; must satisfy 2^PRESC_W > CLK_HZ.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  1 = time advances; 0 = prescaler and counters frozen.
- set_strobe  in  1  single-cycle request to load one field.
- set_field  in  2  field select: 00 = seconds, 01 = minutes, 10 = hours, 11 = invalid.
- set_value  in  6  value to load (hours uses bits [4:0]; bit 5 must be 0).
- seconds  out  6  current seconds, 0..59.
- minutes  out  6  current minutes, 0..59.
- hours  out  5  current hours, 0..23.
- secondP  out  1  one-cycle pulse marking that a new second value is now on the outputs.
- set_err  out  1  one-cycle pulse: the last set_strobe was rejected.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is asynchronous and active-high; it forces prescaler=0, seconds=0, minutes=0, hours=0, secondP=0, set_err=0.
  - No other reset values exist.
- Prescaler:
  - When run=1 it increments each cycle.
  - At terminal count TC it wraps to 0 in the same edge and raises internal tick.
  - When run=0 it holds and no tick occurs.
- Tick latency:
  - At the edge where tick is taken, seconds/minutes/hours update and secondP is registered 1.
  - The new time and secondP=1 are therefore visible together in the following cycle.
  - secondP is never high for more than one cycle.
  - The downstream comparator qualifies its match on secondP, so it sees each time value exactly once.
- Carry chain:
  - seconds 59 -> 0 carries to minutes.
  - minutes 59 -> 0 carries to hours.
  - hours 23 -> 0 (midnight) with no further carry.
  - 23:59:59 -> 00:00:00 in a single tick.
- Set port:
  - set_strobe=1 with a valid field and in-range value loads that field at the edge.
  - Valid ranges: seconds/minutes 0..59, hours 0..23.
  - Other fields are untouched.
  - Loading seconds also clears the prescaler, so the next tick comes TC+1 cycles later.
- Rejected set:
  - Triggered by set_field=11, or a value out of range (e.g. 60 for minutes, 24 for hours).
  - No field changes and set_err pulses for one cycle.
- Simultaneous events:
  - set_strobe has priority over tick in the same cycle.
  - That tick is dropped: no increment and no secondP.
  - The prescaler still wraps (or clears, if seconds is being loaded).
- Setting while run=0 is allowed and behaves identically; secondP stays 0.
- Reset mid-count: any partially elapsed second is discarded; the next tick comes TC+1 cycles after reset release with run=1.
- Widths: all comparisons are unsigned; counters never hold illegal values under any input sequence.

Optional Feature:
- Macro: SIM_PRESCALE_EN.
- When defined: TC = SIM_DIV-1, for fast simulation and bench use.
- When undefined: TC = CLK_HZ-1.
- All other behaviour is identical either way.

Test Plan:
- Tick period (SIM_PRESCALE_EN, SIM_DIV=10): reset, run=1 -> secondP high on exactly every 10th cycle; seconds steps 0,1,2; each secondP coincides with the new seconds value.
- Rollover: set hours=23, minutes=59, seconds=59, run=1 -> after one tick outputs read 00:00:00 with secondP=1 in the same cycle.
- Dose time: set 07:59:59, run=1 -> the cycle showing 08:00:00 has secondP=1, and the prior and next cycles have secondP=0.
- Set rejection: set_field=01, set_value=60 -> minutes unchanged, set_err=1 for one cycle. set_field=11 -> same result. set_field=10, set_value=24 -> hours unchanged, set_err=1.
- Set/tick collision: assert set_strobe (seconds=30) in the tick cycle -> seconds=30, no secondP that cycle; next secondP exactly 10 cycles later with seconds=31.
- Freeze and reset: run=0 for 50 cycles -> outputs static, secondP=0. Async reset asserted mid-second, between clock edges -> outputs 0 immediately; after release with run=1, first secondP after 10 cycles.

Source files
------------

// File: rtl/time_of_day_clock.sv
// time_of_day_clock
//   Real-time time-of-day counter feeding the dose-time comparator. The system
//   clock is divided down to a 1 Hz tick that advances a 24-hour
//   hours:minutes:seconds counter. The time is loaded one field at a time
//   through a strobed set port.
//
// Optional feature macro: SIM_PRESCALE_EN
//   When defined, the prescaler terminal count is SIM_DIV-1 for fast
//   simulation. When undefined, it is CLK_HZ-1.
//
// Parameters
//   CLK_HZ   system clock frequency in Hz
//   SIM_DIV  prescaler length used when SIM_PRESCALE_EN is defined
//   PRESC_W  prescaler width; 2**PRESC_W must exceed the prescaler length
//
// Ports
//   clock       in   system clock, rising-edge active
//   reset       in   asynchronous active-high reset
//   run         in   1 = time advances, 0 = prescaler and counters frozen
//   set_strobe  in   single-cycle request to load one field
//   set_field   in   [1:0] 00 seconds, 01 minutes, 10 hours, 11 invalid
//   set_value   in   [5:0] value to load (hours uses [4:0])
//   seconds     out  [5:0] current seconds, 0..59
//   minutes     out  [5:0] current minutes, 0..59
//   hours       out  [4:0] current hours, 0..23
//   secondP     out  one-cycle pulse: a new second value is on the outputs
//   set_err     out  one-cycle pulse: the last set_strobe was rejected
module time_of_day_clock #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned SIM_DIV = 10,
  parameter int unsigned PRESC_W = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       set_strobe,
  input  logic [1:0] set_field,
  input  logic [5:0] set_value,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       secondP,
  output logic       set_err
);

`ifdef SIM_PRESCALE_EN
  localparam int unsigned TcInt = SIM_DIV - 1;
`else
  localparam int unsigned TcInt = CLK_HZ - 1;
`endif
  localparam logic [PRESC_W-1:0] Tc = PRESC_W'(TcInt);

  localparam logic [1:0] FieldSec  = 2'b00;
  localparam logic [1:0] FieldMin  = 2'b01;
  localparam logic [1:0] FieldHour = 2'b10;
  localparam logic [1:0] FieldBad  = 2'b11;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [5:0]         sec_q, sec_d;
  logic [5:0]         min_q, min_d;
  logic [4:0]         hour_q, hour_d;
  logic               secp_q, secp_d;
  logic               err_q, err_d;

  logic tick;
  logic set_valid;
  logic set_ok;
  logic advance;

  assign tick = run && (presc_q == Tc);

  // Range check of the requested load. Hours compares all six bits so a set
  // bit 5 is rejected rather than silently truncated.
  always_comb begin
    set_valid = 1'b0;
    unique case (set_field)
      FieldSec:  set_valid = (set_value <= 6'd59);
      FieldMin:  set_valid = (set_value <= 6'd59);
      FieldHour: set_valid = (set_value <= 6'd23);
      FieldBad:  set_valid = 1'b0;
      default:   set_valid = 1'b0;
    endcase
  end

  assign set_ok = set_strobe && set_valid;

  // Any strobe, accepted or not, swallows a coincident tick.
  assign advance = tick && !set_strobe;

  // Prescaler: wraps on the tick edge even if the tick itself is dropped.
  // Loading seconds restarts the second so the next tick is a full period away.
  always_comb begin
    presc_d = presc_q;
    if (run) begin
      if (tick) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
    if (set_ok && (set_field == FieldSec)) begin
      presc_d = '0;
    end
  end

  // Time counters with seconds -> minutes -> hours carry.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (set_ok) begin
      unique case (set_field)
        FieldSec:  sec_d  = set_value;
        FieldMin:  min_d  = set_value;
        FieldHour: hour_d = set_value[4:0];
        default:   ;
      endcase
    end else if (advance) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hour_q == 5'd23) begin
            hour_d = 5'd0;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  always_comb begin
    secp_d = advance;
    err_d  = set_strobe && !set_valid;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 5'd0;
      secp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      secp_q  <= secp_d;
      err_q   <= err_d;
    end
  end

  assign seconds = sec_q;
  assign minutes = min_q;
  assign hours   = hour_q;
  assign secondP = secp_q;
  assign set_err = err_q;

endmodule

// File: tb/tb_time_of_day_clock.sv
// Testbench for time_of_day_clock. The DUT is built with a ten-cycle second
// (CLK_HZ = SIM_DIV = 10) so the result is the same with or without
// SIM_PRESCALE_EN. The reference keeps time as seconds-since-midnight.
module tb_time_of_day_clock;

  localparam int Div = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       set_strobe = 1'b0;
  logic [1:0] set_field = 2'b00;
  logic [5:0] set_value = 6'd0;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       secondP;
  logic       set_err;

  int tests = 0;
  int fails = 0;

  time_of_day_clock #(
    .CLK_HZ (Div),
    .SIM_DIV(Div),
    .PRESC_W(26)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .set_strobe(set_strobe),
    .set_field (set_field),
    .set_value (set_value),
    .seconds   (seconds),
    .minutes   (minutes),
    .hours     (hours),
    .secondP   (secondP),
    .set_err   (set_err)
  );

  always #5 clock = ~clock;

  // Reference: time of day as total seconds, cycles elapsed in the current second.
  int m_tod = 0;
  int m_pc  = 0;
  bit m_sp  = 0;
  bit m_err = 0;

  always @(posedge clock or posedge reset) begin
    bit tick, ok;
    int h, m, s;
    if (reset) begin
      m_tod = 0; m_pc = 0; m_sp = 0; m_err = 0;
    end else begin
      tick = run && (m_pc == Div - 1);
      h = m_tod / 3600;
      m = (m_tod / 60) % 60;
      s = m_tod % 60;
      case (set_field)
        2'd0: ok = int'(set_value) < 60;
        2'd1: ok = int'(set_value) < 60;
        2'd2: ok = int'(set_value) < 24;
        default: ok = 0;
      endcase
      m_sp = 0;
      m_err = 0;
      if (run) m_pc = tick ? 0 : m_pc + 1;
      if (set_strobe) begin
        if (ok) begin
          case (set_field)
            2'd0: begin s = int'(set_value); m_pc = 0; end
            2'd1: m = int'(set_value);
            default: h = int'(set_value);
          endcase
          m_tod = h * 3600 + m * 60 + s;
        end else begin
          m_err = 1;
        end
      end else if (tick) begin
        m_tod = (m_tod + 1) % 86400;
        m_sp = 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Packs h:m:s plus pulses so one compare covers the whole output state.
  function automatic int pack(input int h, input int m, input int s, input bit sp,
                              input bit er);
    return (h << 14) | (m << 8) | (s << 2) | (int'(sp) << 1) | int'(er);
  endfunction

  function automatic int dut_state();
    return pack(int'(hours), int'(minutes), int'(seconds), secondP, set_err);
  endfunction

  // Every-cycle comparison against the reference.
  always @(negedge clock) begin
    check("model", dut_state(),
          pack(m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, m_sp, m_err));
  end

  task automatic do_set(input logic [1:0] f, input logic [5:0] v);
    @(negedge clock);
    set_strobe = 1'b1;
    set_field  = f;
    set_value  = v;
    @(negedge clock);
    set_strobe = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  int snap;

  initial begin
    wait_neg(3);
    check("reset_state", dut_state(), 0);
    reset = 1'b0;
    run = 1'b1;

    // Tick period and first seconds.
    for (int i = 1; i <= 3 * Div; i++) begin
      @(negedge clock);
      check("tick_period", int'(secondP), (i % Div == 0) ? 1 : 0);
      if (i % Div == 0) check("tick_seconds", int'(seconds), i / Div);
    end

    // Midnight rollover.
    run = 1'b0;
    do_set(2'd2, 6'd23);
    do_set(2'd1, 6'd59);
    do_set(2'd0, 6'd59);
    run = 1'b1;
    wait_neg(Div - 1);
    check("pre_midnight", dut_state(), pack(23, 59, 59, 0, 0));
    @(negedge clock);
    check("midnight", dut_state(), pack(0, 0, 0, 1, 0));

    // Dose time 08:00:00 seen exactly once.
    run = 1'b0;
    do_set(2'd2, 6'd7);
    do_set(2'd1, 6'd59);
    do_set(2'd0, 6'd59);
    run = 1'b1;
    wait_neg(Div - 1);
    check("dose_prior", int'(secondP), 0);
    @(negedge clock);
    check("dose_time", dut_state(), pack(8, 0, 0, 1, 0));
    @(negedge clock);
    check("dose_next", int'(secondP), 0);

    // Rejected sets.
    run = 1'b0;
    do_set(2'd1, 6'd17);
    check("set_min", int'(minutes), 17);
    do_set(2'd1, 6'd60);
    check("rej_min60", dut_state(), pack(8, 17, 0, 0, 1));
    @(negedge clock);
    check("rej_err_pulse", int'(set_err), 0);
    do_set(2'd3, 6'd5);
    check("rej_field3", dut_state(), pack(8, 17, 0, 0, 1));
    do_set(2'd2, 6'd24);
    check("rej_hour24", dut_state(), pack(8, 17, 0, 0, 1));

    // Set/tick collision.
    do_set(2'd0, 6'd5);
    run = 1'b1;
    wait_neg(Div - 1);
    set_strobe = 1'b1;
    set_field = 2'd0;
    set_value = 6'd30;
    @(negedge clock);
    set_strobe = 1'b0;
    check("collide_set", int'(seconds), 30);
    check("collide_nosp", int'(secondP), 0);
    for (int i = 1; i <= Div; i++) begin
      @(negedge clock);
      check("collide_next_sp", int'(secondP), (i == Div) ? 1 : 0);
    end
    check("collide_next_sec", int'(seconds), 31);

    // Freeze.
    run = 1'b0;
    @(negedge clock);
    snap = dut_state();
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      check("freeze", dut_state(), snap & ~3);
    end

    // Async reset mid-second.
    run = 1'b1;
    wait_neg(4);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check("async_reset", dut_state(), 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i <= Div; i++) begin
      @(negedge clock);
      check("post_reset_sp", int'(secondP), (i == Div) ? 1 : 0);
    end
    check("post_reset_sec", int'(seconds), 1);

    // Random traffic, checked every cycle by the reference.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      run = ($urandom_range(0, 7) != 0);
      set_strobe = ($urandom_range(0, 7) == 0);
      set_field = 2'($urandom_range(0, 3));
      set_value = 6'($urandom_range(0, 63));
    end
    @(negedge clock);
    set_strobe = 1'b0;
    wait_neg(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
